// File: rtl/dldo_switch_driver.sv
// Segmented PMOS power-switch driver for the DLDO: thermometer MSBs with slew limiting,
// binary LSBs, limit-cycle lock monitor and FORCE_OFF shutdown. DWA rotation when DLDO_SWDRV_DWA_EN is defined.
module dldo_switch_driver #(
  parameter int WIDTH    = 14,
  parameter int MSB_BITS = 4,
  parameter int STEP_MAX = 2,
  parameter int WIN_LOG2 = 6,
  parameter int LOCK_REV = 8
) (
  input  logic                        CLKD,
  input  logic                        RST,
  input  logic [WIDTH-1:0]            CODE,
  input  logic                        FORCE_OFF,
  output logic [(2**MSB_BITS)-2:0]    THERM_GB,
  output logic [WIDTH-MSB_BITS-1:0]   BIN_GB,
  output logic [MSB_BITS-1:0]         THERM_CNT,
  output logic                        SLEWING,
  output logic                        LOCKED
);

  localparam int N_SEG = (2**MSB_BITS) - 1;
  localparam int LSB_W = WIDTH - MSB_BITS;
  localparam int CW    = MSB_BITS;
  localparam int SW    = MSB_BITS + 1;

  if (MSB_BITS < 1 || MSB_BITS >= WIDTH) begin : g_bad_msb
    $error("dldo_switch_driver: MSB_BITS out of range");
  end
  if (STEP_MAX < 1 || STEP_MAX > N_SEG) begin : g_bad_step
    $error("dldo_switch_driver: STEP_MAX out of range");
  end
  if (WIN_LOG2 < 1 || WIN_LOG2 > 16) begin : g_bad_win
    $error("dldo_switch_driver: WIN_LOG2 out of range");
  end
  if (LOCK_REV < 1 || LOCK_REV > 255) begin : g_bad_rev
    $error("dldo_switch_driver: LOCK_REV out of range");
  end

  typedef enum logic [1:0] {DIR_NONE, DIR_UP, DIR_DOWN} dir_e;

  logic [WIDTH-1:0]    s;
  logic [CW-1:0]       t;
  logic [CW-1:0]       c_q, c_d;
  logic [CW-1:0]       p_q, p_d;
  logic [SW-1:0]       diff, step;
  logic [N_SEG-1:0]    therm_q, therm_d;
  logic [LSB_W-1:0]    bin_q;
  logic                slew_q, locked_q;
  logic [WIDTH-1:0]    prev_s_q;
  dir_e                dir_q, ds_dir;
  logic [7:0]          rev_cnt_q, rev_inc;
  logic [WIN_LOG2-1:0] win_cnt_q;
  logic                reversal, win_wrap;
  int                  offs;

  assign s = ~CODE;
  assign t = s[WIDTH-1 -: MSB_BITS];

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    c_d  = c_q;
    p_d  = p_q;
    diff = '0;
    step = '0;
    if (FORCE_OFF) begin
      c_d = '0;
    end else if (t > c_q) begin
      diff = SW'(t) - SW'(c_q);
      step = (diff > SW'(STEP_MAX)) ? SW'(STEP_MAX) : diff;
      c_d  = c_q + step[CW-1:0];
    end else if (t < c_q) begin
      diff = SW'(c_q) - SW'(t);
      step = (diff > SW'(STEP_MAX)) ? SW'(STEP_MAX) : diff;
      c_d  = c_q - step[CW-1:0];
`ifdef DLDO_SWDRV_DWA_EN
      // Leaving segments come off the start of the window, so the pointer advances past them.
      p_d  = ((SW'(p_q) + step) >= SW'(N_SEG)) ? CW'(SW'(p_q) + step - SW'(N_SEG))
                                                : CW'(SW'(p_q) + step);
`endif
    end
`ifndef DLDO_SWDRV_DWA_EN
    p_d = '0;
`endif
  end

  // Segment i is on when its distance from P (mod N_SEG) falls below C.
  always_comb begin
    offs    = 0;
    therm_d = '1;
    for (int i = 0; i < N_SEG; i++) begin
      offs       = (i >= int'(p_d)) ? i - int'(p_d) : i + N_SEG - int'(p_d);
      therm_d[i] = (offs >= int'(c_d));
    end
  end

  always_comb begin
    if (s > prev_s_q)      ds_dir = DIR_UP;
    else if (s < prev_s_q) ds_dir = DIR_DOWN;
    else                   ds_dir = DIR_NONE;
    reversal = (ds_dir != DIR_NONE) && (dir_q != DIR_NONE) && (ds_dir != dir_q);
    rev_inc  = (reversal && rev_cnt_q != 8'hFF) ? rev_cnt_q + 8'd1 : rev_cnt_q;
    win_wrap = &win_cnt_q;
  end

  // NOTE: sequential state uses non-blocking assignments only, with the async reset in the sensitivity list.
  always_ff @(posedge CLKD or posedge RST) begin
    if (RST) begin
      c_q       <= '0;
      p_q       <= '0;
      therm_q   <= '1;
      bin_q     <= '1;
      slew_q    <= 1'b0;
      locked_q  <= 1'b0;
      prev_s_q  <= '0;
      dir_q     <= DIR_NONE;
      rev_cnt_q <= '0;
      win_cnt_q <= '0;
    end else begin
      c_q     <= c_d;
      p_q     <= p_d;
      therm_q <= therm_d;
      if (FORCE_OFF) begin
        bin_q     <= '1;
        slew_q    <= 1'b0;
        locked_q  <= 1'b0;
        dir_q     <= DIR_NONE;
        rev_cnt_q <= '0;
        win_cnt_q <= '0;
      end else begin
        bin_q     <= CODE[LSB_W-1:0];
        slew_q    <= (c_d != t);
        prev_s_q  <= s;
        if (ds_dir != DIR_NONE) dir_q <= ds_dir;
        win_cnt_q <= win_cnt_q + 1'b1;
        // A reversal on the closing edge belongs to the window being judged.
        if (win_wrap) begin
          locked_q  <= (rev_inc >= 8'(LOCK_REV));
          rev_cnt_q <= '0;
        end else begin
          rev_cnt_q <= rev_inc;
        end
      end
    end
  end

  assign THERM_GB  = therm_q | {N_SEG{FORCE_OFF}};
  assign BIN_GB    = bin_q | {LSB_W{FORCE_OFF}};
  assign THERM_CNT = c_q;
  assign SLEWING   = slew_q;
  assign LOCKED    = locked_q;

endmodule

// File: doc/dldo_switch_driver.md
Name: dldo_switch_driver

Overview:
- Downstream stage of the DLDO control FSM. Consumes its 14-bit switch code (SROUT-style: bit=1 means switch off) and drives the segmented PMOS power-switch array.
- Upper MSB_BITS of strength are decoded to unit-weight thermometer segments, slew-limited per clock, and rotated by data-weighted averaging (DWA). Lower bits drive binary-weighted switches directly.
- Also provides a limit-cycle lock monitor and a FORCE_OFF fast shutdown.

Parameters:
- WIDTH, 14, code width.
- MSB_BITS, 4, MSBs thermometer-coded; N_SEG = 2^MSB_BITS-1 = 15 segments.
- STEP_MAX, 2, max thermometer count change per clock (>=1).
- WIN_LOG2, 6, lock window length = 2^WIN_LOG2 clocks.
- LOCK_REV, 8, reversals per window needed to assert LOCKED.

Ports:
- CLKD  in  1  clock, rising edge.
- RST  in  1  reset, asynchronous, active-high.
- CODE  in  WIDTH  switch code from FSM; 1 = off; strength S = ~CODE.
- FORCE_OFF  in  1  emergency all-off (e.g. VOH).
- THERM_GB  out  N_SEG  segment gate drives, active-low (0 = on).
- BIN_GB  out  WIDTH-MSB_BITS  binary switch gates = registered CODE LSBs.
- THERM_CNT  out  MSB_BITS  current segment count C.
- SLEWING  out  1  C != target T after the edge.
- LOCKED  out  1  limit-cycle lock flag.

Behaviour:
- Reset (async) values:
  - C=0, pointer P=0.
  - THERM_GB all 1, BIN_GB all 1.
  - SLEWING=0, LOCKED=0.
  - prev_S=0, dir=NONE, rev_cnt=0, win_cnt=0.
- Target: T = S[WIDTH-1:WIDTH-MSB_BITS], range 0..N_SEG.
- Each CLKD edge (FORCE_OFF=0):
  - If T>C: d = min(STEP_MAX, T-C); C += d; P unchanged. Newly enabled segments are indices (P+C_old .. P+C_old+d-1) mod N_SEG.
  - If T<C: d = min(STEP_MAX, C-T); C -= d; P <= (P+d) mod N_SEG. Segments leave from the start.
  - If T==C: C and P hold.
  - Only the segments that change toggle; the enabled set is always contiguous modulo N_SEG.
- THERM_GB is a registered decode of the post-edge C,P: bit i = 0 iff i lies in [P, P+C) mod N_SEG. No combinational decode path drives the pins except FORCE_OFF.
- Latency: CODE to BIN_GB is 1 clock. CODE to first THERM_GB step is 1 clock; full settle takes ceil(|T-C|/STEP_MAX) clocks.
- SLEWING: registered (C_new != T).
- FORCE_OFF:
  - Combinationally ORs THERM_GB and BIN_GB to all 1 (same cycle).
  - At each edge while high: C<=0, P held, BIN_GB reg<=all 1, LOCKED<=0, rev_cnt<=0, win_cnt<=0, dir<=NONE, SLEWING<=0.
  - On release, C ramps from 0 under normal slew rules.
- Lock monitor (every edge, FORCE_OFF=0):
  - dS = sign(S - prev_S); prev_S <= S.
  - If dS!=0 and dir!=NONE and dS!=dir: reversal; rev_cnt increments, saturating at 255.
  - If dS!=0: dir <= dS.
  - win_cnt increments, wrapping at 2^WIN_LOG2-1. On the wrap edge: LOCKED <= (rev_cnt_incl_this_edge >= LOCK_REV); rev_cnt <= 0.
  - A reversal on the wrap edge counts in the closing window only.
- Arithmetic: pointer mod N_SEG done by conditional subtract (N_SEG is not a power of two). C never exceeds N_SEG.
- Parameter values outside range are a synthesis-time error.

Optional Feature:
- Macro: DLDO_SWDRV_DWA_EN.
- Defined: DWA rotation as above.
- Undefined: P is constant 0. Segments fill from index 0 upward and are removed from the top (bits [C-1:0] on). All other behaviour is identical.

Test Plan:
- Reset asserted mid-slew, asynchronous, between edges → THERM_GB=15'h7FFF, BIN_GB=10'h3FF, THERM_CNT=0, LOCKED=0 immediately, without waiting for an edge.
- STEP_MAX=4, CODE 14'h3FFF→14'h03FF (T=15) → THERM_CNT 4,8,12,15 on successive edges. SLEWING=1 after edges 1-3, 0 after edge 4. BIN_GB=10'h3FF after edge 1.
- DWA on, STEP_MAX=4: settle C=3,P=0, then T=1 → C=1,P=2, THERM_GB=15'h7FFB. Then T=4 → segments 2..5 on, THERM_GB=15'h7FC3.
- DWA on: C=15,P=13, T=14 → P=14, segment 13 off only.
- WIN_LOG2=5, LOCK_REV=8: CODE alternates 14'h2000/14'h1FFF each clock → LOCKED=1 at end of first full window. Hold CODE constant → LOCKED=0 at next window wrap.
- FORCE_OFF pulsed mid-slew with LOCKED=1 → outputs all 1 in the same cycle. Next edge: THERM_CNT=0, LOCKED=0. After release, ramp restarts from 0 at STEP_MAX per clock.
